instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Reader side of the 16-bit instruction ROM. Holds the program counter and drives the ROM
//  address. Captures {opcode[15:10], operand[9:0]} into the IF/ID pipeline register.
//  Resolves JMP locally with zero bubbles. Applies branch redirects from the execute stage.
//  Sits between instruction_rom and the decode stage of the MIPS-style pipeline.
// PARAMETERS
//  P_RESET_ADDR  10'd0  PC value loaded on reset
//  P_JMP_OPCODE  `JMP   opcode[15:10] that triggers a local absolute jump
//  P_NOP_WORD    {`NOP,10'd0}  word injected into IF/ID on reset/squash
// PORTS
//  Clock            input   1   single clock; all state on rising edge
//  Reset            input   1   asynchronous, active-high
//  oAddress         output  10  ROM address (= PC), registered
//  iInstruction     input   16  combinational ROM data for oAddress
//  iStall           input   1   decode hazard: hold PC and IF/ID
//  iBranchTaken     input   1   execute stage resolved a taken branch this cycle
//  iBranchPC        input   10  address of the taken branch instruction
//  iBranchOperand   input   10  branch operand {dir[3:0], off[5:0]}
//  oIFID_Instruction output 16  instruction to decode
//  oIFID_PC         output  10  address oIFID_Instruction was fetched from
//  oIFID_Valid      output  1   1 = oIFID_Instruction is a real fetched word
// BEHAVIOUR
//  Reset (async, any time, mid-stall or mid-redirect):
//   - oAddress = P_RESET_ADDR
//   - oIFID_Instruction = P_NOP_WORD, oIFID_PC = 0, oIFID_Valid = 0
//   - FSM = ST_START
//  FSM states:
//   - ST_START: first edge after reset release: IF/ID <= {iInstruction, oAddress}, valid <= 1,
//     PC advances per rules below; -> ST_RUN. (If iStall: stay, hold, valid stays 0.)
//   - ST_RUN: normal fetch; iStall & !iBranchTaken -> ST_HOLD.
//   - ST_HOLD: PC and IF/ID frozen, valid unchanged; !iStall -> ST_RUN;
//     iBranchTaken -> ST_RUN via redirect.
//  Next-PC priority, evaluated every edge (highest first):
//   1. iBranchTaken: PC <= target; IF/ID <= P_NOP_WORD, valid <= 0 (one-cycle squash).
//      target = dir==4'd0 ? iBranchPC+off : iBranchPC-off (dir!=0 treated as backward).
//      Arithmetic is 10-bit modulo 1024, off zero-extended.
//      Examples: PC 13, {0,5} -> 18; PC 22, {1,12} -> 10.
//   2. iStall: hold everything.
//   3. iInstruction[15:10]==P_JMP_OPCODE: PC <= iInstruction[9:0];
//      the JMP word still enters IF/ID with valid=1 (decode treats it as NOP). No bubble.
//   4. Otherwise PC <= PC+1; 10'd1023 wraps to 10'd0.
//  Latency: the word at address A appears on oIFID_* one edge after oAddress==A.
//  Branch taken while a JMP sits at oAddress: branch wins, JMP discarded.
//  Delay-slot words already past IF/ID are not squashed by this block.
//  iStall and iBranchTaken both high: branch wins, stall ignored for that edge.
//  iBranchTaken in ST_START: redirect applies, valid stays 0.
// TESTING
//  - Reset release, ROM words 0..7 sequential, no stall:
//    oAddress 0,1,2,..; oIFID_PC lags by one edge; valid rises on first edge.
//  - Word {`JMP,10'd26} at address 17:
//    cycle after oAddress==17 shows oAddress==26; IF/ID holds the JMP word, valid=1, no bubble.
//  - iBranchTaken with iBranchPC=22, operand {4'd1,6'd12}:
//    next oAddress==10; IF/ID==P_NOP_WORD, valid=0 for one cycle.
//  - iStall high 3 cycles at oAddress==40: oAddress and IF/ID frozen;
//    resumes at 41 after release.
//  - iStall and iBranchTaken together (PC 13, {0,5}):
//    oAddress==18, squash, FSM leaves ST_HOLD.
//  - Sequential wrap and async reset:
//    PC 1023 -> 0. Reset asserted mid-cycle during ST_HOLD forces all outputs
//    to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bundle: ROM read port, hazard/redirect inputs and the IF/ID register outputs.
// The master side is the fetch unit; the slave side is the ROM plus the surrounding pipeline.
interface instruction_fetch_unit_if;
  logic [9:0]  address;
  logic [15:0] instruction;
  logic        stall;
  logic        branch_taken;
  logic [9:0]  branch_pc;
  logic [9:0]  branch_operand;
  logic [15:0] ifid_instruction;
  logic [9:0]  ifid_pc;
  logic        ifid_valid;

  modport master (
    output address,
    output ifid_instruction,
    output ifid_pc,
    output ifid_valid,
    input  instruction,
    input  stall,
    input  branch_taken,
    input  branch_pc,
    input  branch_operand
  );

  modport slave (
    input  address,
    input  ifid_instruction,
    input  ifid_pc,
    input  ifid_valid,
    output instruction,
    output stall,
    output branch_taken,
    output branch_pc,
    output branch_operand
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, reads the ROM, fills IF/ID, resolves JMP locally
// and applies taken-branch redirects from execute with a one-cycle squash.
module instruction_fetch_unit #(
  parameter logic [9:0]  P_RESET_ADDR = 10'd0,
  parameter logic [5:0]  P_JMP_OPCODE = 6'd2,
  parameter logic [15:0] P_NOP_WORD   = 16'h0000
) (
  input logic                      clk,
  input logic                      rst,
  instruction_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t      state_r;
  logic [9:0]  pc_r;
  logic [15:0] ifid_instruction_r;
  logic [9:0]  ifid_pc_r;
  logic        ifid_valid_r;

  logic        is_jmp_s;
  logic [9:0]  fetch_next_pc_s;
  logic [9:0]  branch_target_s;

  // Operand is {dir, off}: dir==0 steps forward, any other dir steps backward; mod 1024.
  function automatic logic [9:0] branch_target(input logic [9:0] bpc, input logic [9:0] op);
    logic [9:0] off;
    off = {4'd0, op[5:0]};
    if (op[9:6] == 4'd0) begin
      branch_target = bpc + off;
    end else begin
      branch_target = bpc - off;
    end
  endfunction

  // Next PC when fetching normally: JMP target or sequential successor.
  always_comb begin
    is_jmp_s        = (bus.instruction[15:10] == P_JMP_OPCODE);
    fetch_next_pc_s = pc_r + 10'd1;
    branch_target_s = branch_target(bus.branch_pc, bus.branch_operand);
    if (is_jmp_s) begin
      fetch_next_pc_s = bus.instruction[9:0];
    end else begin
      fetch_next_pc_s = pc_r + 10'd1;
    end
  end

  // PC, IF/ID register and control FSM; redirect outranks stall, stall outranks fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r               <= P_RESET_ADDR;
      ifid_instruction_r <= P_NOP_WORD;
      ifid_pc_r          <= 10'd0;
      ifid_valid_r       <= 1'b0;
      state_r            <= ST_START;
    end else if (bus.branch_taken) begin
      pc_r               <= branch_target_s;
      ifid_instruction_r <= P_NOP_WORD;
      ifid_pc_r          <= 10'd0;
      ifid_valid_r       <= 1'b0;
      state_r            <= ST_RUN;
    end else if (bus.stall) begin
      case (state_r)
        ST_START: state_r <= ST_START;
        ST_RUN:   state_r <= ST_HOLD;
        ST_HOLD:  state_r <= ST_HOLD;
        default:  state_r <= ST_START;
      endcase
    end else begin
      // The JMP word itself still goes to decode as a valid (no-op) instruction.
      pc_r               <= fetch_next_pc_s;
      ifid_instruction_r <= bus.instruction;
      ifid_pc_r          <= pc_r;
      ifid_valid_r       <= 1'b1;
      state_r            <= ST_RUN;
    end
  end

  assign bus.address          = pc_r;
  assign bus.ifid_instruction = ifid_instruction_r;
  assign bus.ifid_pc          = ifid_pc_r;
  assign bus.ifid_valid       = ifid_valid_r;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus random
// stall/branch traffic against a cycle-level behavioural model of the fetch stage.
module tb_instruction_fetch_unit;
  localparam logic [5:0]  JMP = 6'd2;
  localparam logic [15:0] NOP = 16'h0000;

  logic clk;
  logic rst;
  int   compared   = 0;
  int   mismatched = 0;
  logic cmp_en     = 1'b0;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(
    .P_RESET_ADDR(10'd0),
    .P_JMP_OPCODE(JMP),
    .P_NOP_WORD  (NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [15:0] rom [0:1023];
  assign bus.instruction = rom[bus.address];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model state
  logic [9:0]  m_pc;
  logic [9:0]  m_ifpc;
  logic [15:0] m_instr;
  logic        m_valid;

  function automatic logic [9:0] tgt(input logic [9:0] bpc, input logic [9:0] op);
    int d;
    if (op[9:6] == 4'd0) d = int'(bpc) + int'(op[5:0]);
    else                 d = int'(bpc) - int'(op[5:0]) + 1024;
    return 10'(d % 1024);
  endfunction

  function automatic logic [15:0] nonjmp(input logic [15:0] w);
    logic [15:0] r;
    r = w;
    if (r[15:10] == JMP) r[15:10] = JMP + 6'd1;
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc    <= 10'd0;
      m_ifpc  <= 10'd0;
      m_instr <= NOP;
      m_valid <= 1'b0;
    end else if (bus.branch_taken) begin
      m_pc    <= tgt(bus.branch_pc, bus.branch_operand);
      m_instr <= NOP;
      m_valid <= 1'b0;
    end else if (!bus.stall) begin
      m_instr <= rom[m_pc];
      m_ifpc  <= m_pc;
      m_valid <= 1'b1;
      m_pc    <= (rom[m_pc][15:10] == JMP) ? rom[m_pc][9:0] : 10'((int'(m_pc) + 1) % 1024);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst && cmp_en) begin
      chk("model_address", 32'(bus.address), 32'(m_pc));
      chk("model_valid", 32'(bus.ifid_valid), 32'(m_valid));
      chk("model_ifid_instr", 32'(bus.ifid_instruction), 32'(m_instr));
      if (m_valid) chk("model_ifid_pc", 32'(bus.ifid_pc), 32'(m_ifpc));
    end
  end

  task automatic drive(input logic st, input logic bt, input logic [9:0] bpc, input logic [9:0] op);
    bus.stall          = st;
    bus.branch_taken   = bt;
    bus.branch_pc      = bpc;
    bus.branch_operand = op;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input logic [9:0] a);
    drive(1'b0, 1'b1, a, 10'd0);
    tick();
    drive(1'b0, 1'b0, 10'd0, 10'd0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_address"}, 32'(bus.address), 32'd0);
    chk({tag, "_ifid_instr"}, 32'(bus.ifid_instruction), 32'(NOP));
    chk({tag, "_ifid_pc"}, 32'(bus.ifid_pc), 32'd0);
    chk({tag, "_valid"}, 32'(bus.ifid_valid), 32'd0);
  endtask

  initial begin
    logic [15:0] w;
    for (int i = 0; i < 1024; i++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 7) == 0) w[15:10] = JMP;
      else w = nonjmp(w);
      rom[i] = w;
    end
    for (int i = 0; i < 13; i++) rom[i] = nonjmp(rom[i]);
    for (int i = 39; i < 43; i++) rom[i] = nonjmp(rom[i]);
    rom[18]   = nonjmp(rom[18]);
    rom[1023] = nonjmp(rom[1023]);
    rom[17]   = {JMP, 10'd26};

    rst = 1'b1;
    drive(1'b0, 1'b0, 10'd0, 10'd0);
    repeat (2) @(posedge clk);
    #1;
    chk_reset_values("reset");
    rst    = 1'b0;
    cmp_en = 1'b1;

    // Sequential fetch from reset: IF/ID lags the address by one edge
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("seq_address", 32'(bus.address), 32'(i));
      chk("seq_ifid_pc", 32'(bus.ifid_pc), 32'(i - 1));
      chk("seq_valid", 32'(bus.ifid_valid), 32'd1);
    end

    // Local JMP at 17 -> 26 without a bubble
    go_to(10'd17);
    tick();
    chk("jmp_address", 32'(bus.address), 32'd26);
    chk("jmp_ifid_instr", 32'(bus.ifid_instruction), 32'h081A);
    chk("jmp_ifid_pc", 32'(bus.ifid_pc), 32'd17);
    chk("jmp_valid", 32'(bus.ifid_valid), 32'd1);

    // Backward branch 22 - 12 = 10 with squash
    drive(1'b0, 1'b1, 10'd22, {4'd1, 6'd12});
    tick();
    chk("br_address", 32'(bus.address), 32'd10);
    chk("br_model_pc", 32'(m_pc), 32'd10);
    chk("br_ifid_instr", 32'(bus.ifid_instruction), 32'(NOP));
    chk("br_valid", 32'(bus.ifid_valid), 32'd0);
    drive(1'b0, 1'b0, 10'd0, 10'd0);
    tick();
    chk("br_after_address", 32'(bus.address), 32'd11);
    chk("br_after_valid", 32'(bus.ifid_valid), 32'd1);

    // Three-cycle stall at address 40
    go_to(10'd39);
    tick();
    drive(1'b1, 1'b0, 10'd0, 10'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_address", 32'(bus.address), 32'd40);
      chk("stall_ifid_pc", 32'(bus.ifid_pc), 32'd39);
      chk("stall_valid", 32'(bus.ifid_valid), 32'd1);
    end
    drive(1'b0, 1'b0, 10'd0, 10'd0);
    tick();
    chk("unstall_address", 32'(bus.address), 32'd41);
    chk("unstall_ifid_pc", 32'(bus.ifid_pc), 32'd40);

    // Stall and branch together while holding: branch wins, 13 + 5 = 18
    drive(1'b1, 1'b0, 10'd0, 10'd0);
    tick();
    drive(1'b1, 1'b1, 10'd13, {4'd0, 6'd5});
    tick();
    chk("stbr_address", 32'(bus.address), 32'd18);
    chk("stbr_model_pc", 32'(m_pc), 32'd18);
    chk("stbr_valid", 32'(bus.ifid_valid), 32'd0);
    drive(1'b0, 1'b0, 10'd0, 10'd0);
    tick();
    chk("stbr_after_address", 32'(bus.address), 32'd19);

    // Wrap-around: sequential 1023 -> 0 and modulo branch targets
    go_to(10'd1023);
    tick();
    chk("wrap_address", 32'(bus.address), 32'd0);
    chk("wrap_ifid_pc", 32'(bus.ifid_pc), 32'd1023);
    drive(1'b0, 1'b1, 10'd1020, {4'd0, 6'd10});
    tick();
    chk("fwd_wrap_address", 32'(bus.address), 32'd6);
    drive(1'b0, 1'b1, 10'd3, {4'd2, 6'd5});
    tick();
    chk("bwd_wrap_address", 32'(bus.address), 32'd1022);
    chk("bwd_wrap_model_pc", 32'(m_pc), 32'd1022);

    // Asynchronous reset mid-cycle while holding
    go_to(10'd40);
    tick();
    drive(1'b1, 1'b0, 10'd0, 10'd0);
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk_reset_values("async_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    // Stall right after reset release: nothing fetched, valid stays low
    tick();
    tick();
    chk("start_stall_address", 32'(bus.address), 32'd0);
    chk("start_stall_valid", 32'(bus.ifid_valid), 32'd0);
    drive(1'b0, 1'b0, 10'd0, 10'd0);
    tick();
    chk("restart_address", 32'(bus.address), 32'd1);
    chk("restart_valid", 32'(bus.ifid_valid), 32'd1);

    // Random traffic checked cycle by cycle against the model
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
            10'($urandom), 10'($urandom));
      tick();
    end

    drive(1'b0, 1'b0, 10'd0, 10'd0);
    @(negedge clk);
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
